// File: rtl/dqpsk_pkg.sv
// Shared DQPSK definitions: symbol type, phase-index constants and symbol/index mapping.
// Used by diff_decode, diff_encode and the slicer.
package dqpsk_pkg;

    typedef logic [1:0] sym_t;
    typedef logic [1:0] idx_t;

    // Quadrant symbols in encoder state order (90 degree steps).
    localparam sym_t SYM_P0   = 2'b00;
    localparam sym_t SYM_P90  = 2'b10;
    localparam sym_t SYM_P180 = 2'b11;
    localparam sym_t SYM_P270 = 2'b01;

    localparam idx_t IDX_0   = 2'd0;
    localparam idx_t IDX_90  = 2'd1;
    localparam idx_t IDX_180 = 2'd2;
    localparam idx_t IDX_270 = 2'd3;

    function automatic idx_t sym2idx(input sym_t s);
        idx_t idx;
        case (s)
            SYM_P0:   idx = IDX_0;
            SYM_P90:  idx = IDX_90;
            SYM_P180: idx = IDX_180;
            default:  idx = IDX_270;
        endcase
        return idx;
    endfunction

    function automatic sym_t idx2sym(input idx_t idx);
        sym_t s;
        case (idx)
            IDX_0:   s = SYM_P0;
            IDX_90:  s = SYM_P90;
            IDX_180: s = SYM_P180;
            default: s = SYM_P270;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/dqpsk_phase_step.sv
// Combinational phase-step decoder: dibit for the 90-degree step from prev to cur.
module dqpsk_phase_step
    import dqpsk_pkg::*;
(
    input  logic [1:0] cur,
    input  logic [1:0] prev,
    output logic [1:0] dibit
);

    idx_t step;

    // The 2-bit subtract wraps naturally, giving (cur - prev) mod 4.
    assign step  = sym2idx(cur) - sym2idx(prev);
    assign dibit = idx2sym(step);

endmodule

// File: rtl/diff_decode.sv
// Differential DQPSK decoder with valid/ready in, registered valid/ready out.
// Optional handoff counter on sym_count when DIFF_DECODE_SYMCNT_EN is defined.
module diff_decode
    import dqpsk_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [1:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             resync,
    output logic [1:0]       out_data,
    output logic             valid_diff_decode,
`ifdef DIFF_DECODE_SYMCNT_EN
    input  logic             out_ready,
    output logic [CNT_W-1:0] sym_count
`else
    input  logic             out_ready
`endif
);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("diff_decode: CNT_W must be at least 1");
    end

    sym_t ref_sym;
    sym_t prev_sym;
    sym_t dibit;
    logic accept;
    logic handoff;

    assign in_ready = !valid_diff_decode || out_ready;
    assign accept   = in_valid && in_ready;
    assign handoff  = valid_diff_decode && out_ready;

    // resync takes effect for a symbol accepted in the same cycle.
    assign prev_sym = resync ? SYM_P0 : ref_sym;

    dqpsk_phase_step u_phase_step (
        .cur   (in_data),
        .prev  (prev_sym),
        .dibit (dibit)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ref_sym           <= SYM_P0;
            out_data          <= 2'b00;
            valid_diff_decode <= 1'b0;
        end else if (accept) begin
            out_data          <= dibit;
            ref_sym           <= in_data;
            valid_diff_decode <= 1'b1;
        end else begin
            if (handoff) begin
                valid_diff_decode <= 1'b0;
            end
            if (resync) begin
                ref_sym <= SYM_P0;
            end
        end
    end

`ifdef DIFF_DECODE_SYMCNT_EN
    // Counts handoffs only; resync deliberately leaves it alone.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sym_count <= '0;
        end else if (handoff) begin
            sym_count <= sym_count + 1'b1;
        end
    end
`endif

endmodule

// File: doc/diff_decode.md
# diff_decode

Differential DQPSK decoder on the receive side of the modem, directly after symbol slicing. It recovers the 2-bit data dibit from the phase step between consecutive received quadrant symbols, so it is the exact inverse of `diff_encode`. It accepts sliced symbols on a valid/ready interface and presents decoded dibits on a registered valid/ready interface to the downstream de-mapper.

## Interface
Parameters:
- `CNT_W`, 16: width of the decoded-symbol counter (only used when `DIFF_DECODE_SYMCNT_EN` is defined).

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rstn` in 1: reset, asynchronous and active-low.
- `in_data` in 2: received quadrant symbol from the slicer.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: the block accepts `in_data` this cycle.
- `resync` in 1: forces the phase reference to `2'b00`, matching an encoder reset.
- `out_data` out 2: decoded dibit.
- `valid_diff_decode` out 1: `out_data` is valid.
- `out_ready` in 1: downstream accepts `out_data`.
- `sym_count` out `CNT_W`: number of decoded dibits handed off (only with `DIFF_DECODE_SYMCNT_EN`).

## Operation
- Phase index: `00`=0, `10`=1, `11`=2, `01`=3 (90° steps in encoder state order).
- Dibit for a step d = (idx(cur) − idx(prev)) mod 4, computed as a 2-bit unsigned subtract with natural wrap: d=0→`00`, 1→`10`, 2→`11`, 3→`01`.
- A symbol is accepted when `in_valid && in_ready`. On accept:
  - `out_data` is set to the dibit for (`in_data`, ref).
  - ref is set to `in_data`.
  - `valid_diff_decode` is set to 1.
- `in_ready = !valid_diff_decode || out_ready`. This is combinational, with no bubble at full throughput.
- On a handoff (`valid_diff_decode && out_ready`) with no new accept in the same cycle, `valid_diff_decode` is cleared to 0.
- Stall (`valid_diff_decode && !out_ready`): `out_data`, `valid_diff_decode` and ref all hold. The input is not accepted.
- `resync`:
  - ref becomes `00` for this cycle's decode. A symbol accepted in the same cycle is decoded against `00`, and ref then takes that symbol.
  - Without an accept, ref becomes `00` at the clock edge.
  - A pending output is not dropped.
- `in_valid` low: no state changes except the handoff clear and `resync`.

## Timing
- Reset values: ref=`00`, `out_data`=`00`, `valid_diff_decode`=0, `sym_count`=0. `in_ready` is 1 while reset is deasserted and no output is pending.
- Latency is 1 cycle from accept to `valid_diff_decode`. Throughput is 1 symbol/cycle while `out_ready`=1.
- Reset asserted mid-stream: all state clears immediately (asynchronous) and any pending dibit is lost. The first symbol after release is decoded against `00`.
- Removal of `rstn` is synchronised externally. No internal reset synchroniser.

## Configuration
- With `DIFF_DECODE_SYMCNT_EN` defined:
  - `sym_count` increments by 1 on each handoff (`valid_diff_decode && out_ready`).
  - It wraps from all-ones to 0 and is cleared by `rstn` only (not by `resync`).
- Without the macro:
  - The `sym_count` port and the counter are absent.
  - All other behaviour is identical.

## Structure
- Shared package `dqpsk_pkg`:
  - 2-bit symbol typedef.
  - Phase-index constants.
  - Functions `sym2idx`/`idx2sym`, reused by `diff_encode` rework and the slicer.
- Sub-module `dqpsk_phase_step`:
  - Combinational; inputs are the current and previous symbol, output is the dibit.
  - Instantiated once in `diff_decode`.

## Test plan
- Encoder round trip: after reset, input symbols `10,01,11,11` with `out_ready`=1 → `out_data` `10,11,01,00` on consecutive cycles, each 1 cycle after its accept.
- Stall: hold `out_ready`=0 for 3 cycles after the first output.
  - Required during the stall: `in_ready`=0, and `out_data`/`valid_diff_decode` stable.
  - Symbol `11` presented during the stall is decoded against the last accepted symbol only after release (ref `10` → `01`... i.e. dibit `10`).
- `resync`: with ref=`11`, pulse `resync` together with accept of `10` → `out_data`=`10` (not `01`). The next symbol `10` → `00`.
- Wrap-around: sequence `01,00` from reset → `01` then `10`. This checks that the mod-4 subtract wraps (0−3 and 3−0).
- Async reset mid-stream: assert `rstn`=0 between edges while `valid_diff_decode`=1.
  - Outputs clear immediately.
  - After release, `11` decodes to `11`.
- `DIFF_DECODE_SYMCNT_EN` with `CNT_W`=4: 17 handoffs → `sym_count`=1. Stall cycles do not count; `resync` does not clear it.
